// File: rtl/ntsc_pkg.sv
// Shared NTSC timing constants, line-type encoding and small helpers for the
// ntsc_timing_gen block. All counts are in 32 MHz pixel clocks.
package ntsc_pkg;

  localparam logic [10:0] H_TOTAL     = 11'd2032;
  localparam logic [10:0] H_SYNC      = 11'd150;
  localparam logic [10:0] H_EQ        = 11'd75;
  localparam logic [10:0] H_BROAD     = 11'd866;
  localparam logic [10:0] H_HALF      = 11'd1016;
  localparam logic [10:0] BURST_START = 11'd169;
  localparam logic [10:0] BURST_LEN   = 11'd80;
  localparam logic [10:0] ACT_START   = 11'd340;
  localparam logic [10:0] ACT_LEN     = 11'd1664;

  localparam logic [8:0] V_TOTAL       = 9'd262;
  localparam logic [8:0] V_VSYNC_START = 9'd3;
  localparam logic [8:0] V_EQ2_START   = 9'd6;
  localparam logic [8:0] V_BLANK_START = 9'd9;
  localparam logic [8:0] V_ACT_START   = 9'd20;
  localparam logic [8:0] V_ACT_LEN     = 9'd240;

  localparam logic [3:0] BLANK_LVL = 4'd4;
  localparam logic [3:0] SYNC_LVL  = 4'd0;

  typedef enum logic [1:0] {
    LT_EQ     = 2'd0,
    LT_VSYNC  = 2'd1,
    LT_BLANK  = 2'd2,
    LT_ACTIVE = 2'd3
  } line_type_t;

  // Equalising lines bracket the broad-pulse lines; everything outside the
  // active window that is not vertical sync is plain blanking.
  function automatic line_type_t line_type_of(input logic [8:0] v);
    if (v < V_VSYNC_START)                                   return LT_EQ;
    else if (v < V_EQ2_START)                                return LT_VSYNC;
    else if (v < V_BLANK_START)                              return LT_EQ;
    else if (v >= V_ACT_START && v < V_ACT_START + V_ACT_LEN) return LT_ACTIVE;
    else                                                     return LT_BLANK;
  endfunction

  function automatic logic [3:0] clamp_black(input logic [3:0] luma);
    return (luma > BLANK_LVL) ? luma : BLANK_LVL;
  endfunction

endpackage

// File: rtl/ntsc_line_decode.sv
// Combinational decode of horizontal position and line type into the
// sync, colorburst and active-video windows. Sync always wins.
module ntsc_line_decode
  import ntsc_pkg::*;
(
  input  logic [10:0] hcnt,
  input  logic [1:0]  line_type,
  output logic        sync,
  output logic        burst,
  output logic        active
);

  logic sync_raw;
  logic burst_raw;
  logic active_raw;
  logic in_hsync;
  logic in_burst;
  logic in_active;

  assign in_hsync  = hcnt < H_SYNC;
  assign in_burst  = (hcnt >= BURST_START) && (hcnt < BURST_START + BURST_LEN);
  assign in_active = (hcnt >= ACT_START) && (hcnt < ACT_START + ACT_LEN);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    sync_raw   = 1'b0;
    burst_raw  = 1'b0;
    active_raw = 1'b0;
    case (line_type_t'(line_type))
      LT_EQ: begin
        sync_raw = (hcnt < H_EQ) || ((hcnt >= H_HALF) && (hcnt < H_HALF + H_EQ));
      end
      LT_VSYNC: begin
        sync_raw = (hcnt < H_BROAD) || ((hcnt >= H_HALF) && (hcnt < H_HALF + H_BROAD));
      end
      LT_BLANK: begin
        sync_raw  = in_hsync;
        burst_raw = in_burst;
      end
      LT_ACTIVE: begin
        sync_raw   = in_hsync;
        burst_raw  = in_burst;
        active_raw = in_active;
      end
      default: ;
    endcase
  end

  // Mutual exclusion guards against overlapping windows from bad constants.
  assign sync   = sync_raw;
  assign burst  = burst_raw & ~sync_raw;
  assign active = active_raw & ~sync_raw & ~burst_raw;

endmodule

// File: rtl/ntsc_timing_gen.sv
// Progressive 262-line NTSC timing generator with pixel fetch and luma+sync
// output. Define NTSC_TESTBARS_EN to replace source luma with 8 grey bars.
module ntsc_timing_gen
  import ntsc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  pix_luma,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [7:0]  pix_y,
  output logic        active_dly,
  output logic        cb_dly,
  output logic [3:0]  luma_sync_d2,
  output logic        frame_start
);

  logic [10:0] hcnt;
  logic [8:0]  vcnt;
  logic [1:0]  line_type;
  logic        sync;
  logic        burst;
  logic        active;
  logic        sync_dly;
  logic [3:0]  src_luma;

  assign line_type = line_type_of(vcnt);

  ntsc_line_decode u_decode (
    .hcnt      (hcnt),
    .line_type (line_type),
    .sync      (sync),
    .burst     (burst),
    .active    (active)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_TOTAL - 11'd1) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_TOTAL - 9'd1) ? '0 : vcnt + 9'd1;
    end else begin
      hcnt <= hcnt + 11'd1;
    end
  end

  // Stage 1: all window flags share one register so burst and active stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      active_dly  <= 1'b0;
      cb_dly      <= 1'b0;
      sync_dly    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_req     <= active;
      active_dly  <= active;
      cb_dly      <= burst;
      sync_dly    <= sync;
      frame_start <= (hcnt == '0) && (vcnt == '0);
      if (active) begin
        pix_x <= hcnt - ACT_START;
        pix_y <= 8'(vcnt - V_ACT_START);
      end
    end
  end

`ifdef NTSC_TESTBARS_EN
  logic unused_pix_luma;
  assign unused_pix_luma = ^pix_luma;
  assign src_luma        = {1'b1, pix_x[10:8]};
`else
  assign src_luma = pix_luma;
`endif

  // Stage 2: the source answers the stage-1 request one clock later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      luma_sync_d2 <= BLANK_LVL;
    end else if (sync_dly) begin
      luma_sync_d2 <= SYNC_LVL;
    end else if (active_dly) begin
      luma_sync_d2 <= clamp_black(src_luma);
    end else begin
      luma_sync_d2 <= BLANK_LVL;
    end
  end

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Directed self-checking bench for ntsc_timing_gen: reset, frame period,
// per-line sync/burst/active windows, pixel path and mid-line reset.
`timescale 1ns/1ps
module tb_ntsc_timing_gen;

  localparam int HT    = 2032;
  localparam int VT    = 262;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  pix_luma = 4'd0;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [7:0]  pix_y;
  logic        active_dly;
  logic        cb_dly;
  logic [3:0]  luma_sync_d2;
  logic        frame_start;

  ntsc_timing_gen dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_luma     (pix_luma),
    .pix_req      (pix_req),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .active_dly   (active_dly),
    .cb_dly       (cb_dly),
    .luma_sync_d2 (luma_sync_d2),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int k = 0;

  int act_cnt  [VT];
  int cb_cnt   [VT];
  int cb_first [VT];
  int nruns    [VT];
  int run_start[VT][2];
  int run_len  [VT][2];
  bit prev_zero;
  int fs_count;
  int last_fs_k;
  int fs_interval;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int v = 0; v < VT; v++) begin
      act_cnt[v]  = 0;
      cb_cnt[v]   = 0;
      cb_first[v] = -1;
      nruns[v]    = 0;
      for (int r = 0; r < 2; r++) begin
        run_start[v][r] = -1;
        run_len[v][r]   = 0;
      end
    end
    prev_zero   = 1'b0;
    fs_count    = 0;
    last_fs_k   = 0;
    fs_interval = 0;
  endtask

  // One clock; k counts edges since reset release. Stage-1 outputs after edge
  // k describe counter index k-1, luma_sync_d2 describes index k-2.
  task automatic step();
    int i1, i2, h, v;
    @(posedge clk);
    #1;
    k++;
    if (frame_start === 1'b1) begin
      if (fs_count > 0) fs_interval = k - last_fs_k;
      last_fs_k = k;
      fs_count++;
    end
    i1 = k - 1;
    h  = i1 % HT;
    v  = (i1 / HT) % VT;
    if (active_dly === 1'b1) act_cnt[v]++;
    if (cb_dly === 1'b1) begin
      if (cb_cnt[v] == 0) cb_first[v] = h;
      cb_cnt[v]++;
    end
    if (k >= 2) begin
      i2 = k - 2;
      h  = i2 % HT;
      v  = (i2 / HT) % VT;
      if (luma_sync_d2 === 4'd0) begin
        if (!prev_zero || h == 0) begin
          if (nruns[v] < 2) run_start[v][nruns[v]] = h;
          nruns[v]++;
        end
        if (nruns[v] <= 2) run_len[v][nruns[v]-1]++;
        prev_zero = 1'b1;
      end else begin
        prev_zero = 1'b0;
      end
    end
  endtask

  task automatic goto(input int target);
    while (k < target) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pix_req"},    pix_req,      0);
    check({tag, "_pix_x"},      pix_x,        0);
    check({tag, "_pix_y"},      pix_y,        0);
    check({tag, "_active_dly"}, active_dly,   0);
    check({tag, "_cb_dly"},     cb_dly,       0);
    check({tag, "_luma"},       luma_sync_d2, 4);
    check({tag, "_frame_start"}, frame_start, 0);
  endtask

  initial begin
    int kreq;
    int cb_sum;
    int s;
    clear_stats();

    // Reset applied from time zero.
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst0");

    reset_n = 1'b1;
    k = 0;
    step();
    check("fs_first", frame_start, 1);
    check("act_k1", active_dly, 0);
    step();
    check("fs_width", frame_start, 0);
    check("luma_line0_h0_sync", luma_sync_d2, 0);

    // Pixel path on line 30: x=0 requested at edge kreq.
    kreq = 30 * HT + 340 + 1;
    goto(kreq - 1);
    pix_luma = 4'd13;
    step();
    check("l30_pix_req", pix_req, 1);
    check("l30_active_dly", active_dly, 1);
    check("l30_pix_x0", pix_x, 0);
    check("l30_pix_y", pix_y, 10);
    check("l30_luma_before", luma_sync_d2, 4);
    step();
    check("l30_pix_x1", pix_x, 1);
`ifdef NTSC_TESTBARS_EN
    check("l30_bar_x0", luma_sync_d2, 8);
`else
    check("l30_luma13", luma_sync_d2, 13);
`endif
    pix_luma = 4'd2;
    step();
`ifdef NTSC_TESTBARS_EN
    check("l30_bar_x1", luma_sync_d2, 8);
`else
    check("l30_luma2_clamp", luma_sync_d2, 4);
`endif
    pix_luma = 4'd13;
    goto(kreq + 256);
    check("l30_pix_x256", pix_x, 256);
    step();
`ifdef NTSC_TESTBARS_EN
    check("l30_bar_x256", luma_sync_d2, 9);
`else
    check("l30_luma13_b", luma_sync_d2, 13);
`endif
    goto(kreq + 1663);
    check("l30_pix_x1663", pix_x, 1663);
    check("l30_req_last", pix_req, 1);
    step();
    check("l30_req_end", pix_req, 0);
    check("l30_pix_x_hold", pix_x, 1663);
`ifdef NTSC_TESTBARS_EN
    check("l30_bar_x1663", luma_sync_d2, 14);
`else
    check("l30_luma_last", luma_sync_d2, 13);
`endif
    pix_luma = 4'd0;

    // Per-line window statistics for lines 0..30.
    goto(31 * HT + 5);
    cb_sum = 0;
    for (int v = 0; v <= 8; v++) cb_sum += cb_cnt[v];
    check("cb_lines0_8", cb_sum, 0);
    check("l1_runs", nruns[1], 2);
    check("l1_start0", run_start[1][0], 0);
    check("l1_len0", run_len[1][0], 75);
    check("l1_start1", run_start[1][1], 1016);
    check("l1_len1", run_len[1][1], 75);
    check("l4_runs", nruns[4], 2);
    check("l4_start0", run_start[4][0], 0);
    check("l4_len0", run_len[4][0], 866);
    check("l4_start1", run_start[4][1], 1016);
    check("l4_len1", run_len[4][1], 866);
    check("l25_runs", nruns[25], 1);
    check("l25_sync_start", run_start[25][0], 0);
    check("l25_sync_len", run_len[25][0], 150);
    check("l25_cb_len", cb_cnt[25], 80);
    check("l25_cb_first", cb_first[25], 169);
    check("l25_act_len", act_cnt[25], 1664);
    check("l9_cb_len", cb_cnt[9], 80);
    check("l9_act_len", act_cnt[9], 0);
    check("l19_act_len", act_cnt[19], 0);
    check("l20_act_len", act_cnt[20], 1664);

    // Frame period.
    goto(FRAME);
    check("fs_before_wrap", frame_start, 0);
    step();
    check("fs_second", frame_start, 1);
    check("fs_interval", fs_interval, FRAME);
    check("fs_count", fs_count, 2);

    // Reset mid-line at counter state hcnt=1200, vcnt=100 of the second frame.
    s = FRAME + 100 * HT + 1200;
    goto(s);
    check("pre_rst_active", active_dly, 1);
    check("pre_rst_pix_x", pix_x, 859);
    check("pre_rst_pix_y", pix_y, 80);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    reset_n = 1'b1;
    k = 0;
    step();
    check("fs_restart", frame_start, 1);
    step();
    check("fs_restart_width", frame_start, 0);
    check("restart_luma_h0", luma_sync_d2, 0);
    goto(77);
    check("restart_luma_h75", luma_sync_d2, 4);
    goto(170);
    check("restart_cb_h169", cb_dly, 0);
    goto(1018);
    check("restart_luma_h1016", luma_sync_d2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
